// File: rtl/picorv32_mdu_pkg.sv
// picorv32_mdu_pkg
// Shared definitions for the PCPI multiply/divide dispatch controller.
// It holds:
//   - the RV32M opcode and funct7 constants,
//   - the funct3 operation codes,
//   - the controller FSM state type,
//   - the M-extension instruction decode helper.
package picorv32_mdu_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 codes; bit 2 set means the divider owns the operation
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } mdu_state_e;

  // True for any RV32M instruction (MUL..REMU)
  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/picorv32_pcpi_mdu_ctrl.sv
// picorv32_pcpi_mdu_ctrl
// Dispatches RV32M PCPI requests from the core to an external multiplier or divider.
// It returns the selected unit's result to the core as a single pcpi_ready pulse.
//
// Ports
//   clk, reset (sync, active high)
//   pcpi_valid/insn/rs1/rs2       : core request
//   pcpi_wr/rd/wait/ready         : core response
//   mul_valid, div_valid          : per-unit request strobes
//   unit_insn/rs1/rs2             : latched operands shared by both units
//   mul_*/div_* wr/rd/wait/ready  : unit responses
//   timeout_evt                   : one-cycle pulse when a request is abandoned
//
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
module picorv32_pcpi_mdu_ctrl
  import picorv32_mdu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mul_valid,
  output logic        div_valid,
  output logic [31:0] unit_insn,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  input  logic        mul_wr,
  input  logic [31:0] mul_rd,
  input  logic        mul_wait,
  input  logic        mul_ready,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready,
  output logic        timeout_evt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e  state_r, state_s;
  logic        sel_div_r;
  logic [CNT_W-1:0] cnt_r, cnt_inc_s;
  logic [31:0] insn_r, rs1_r, rs2_r;
  logic        rsp_wr_r;
  logic [31:0] rsp_rd_r;
  logic        timeout_r;

  logic        accept_s;
  logic        unit_ready_s, unit_wr_s;
  logic [31:0] unit_rd_s;
  logic        timeout_s;

  // The units' wait lines carry no information the controller needs
  logic unused_ok_s;
  assign unused_ok_s = &{1'b0, mul_wait, div_wait};

  // Request decode, 2:1 response mux on sel_div and busy-counter timeout detection
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && pcpi_valid && is_muldiv(pcpi_insn);
    unit_ready_s = sel_div_r ? div_ready : mul_ready;
    unit_wr_s    = sel_div_r ? div_wr    : mul_wr;
    unit_rd_s    = sel_div_r ? div_rd    : mul_rd;
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
    // The abandon fires on the ISSUE cycle that brings the count to the limit,
    // so the core sees exactly TIMEOUT_CYCLES wait cycles; ready takes priority
    timeout_s = (state_r == ST_ISSUE) && !unit_ready_s && (cnt_inc_s == CNT_MAX);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (unit_ready_s) begin
          state_s = ST_RESP;
        end else if (timeout_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_RESP: begin
        state_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Hold here until the core drops valid so a held request is not reissued
        if (pcpi_valid) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand latches, busy counter and captured response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sel_div_r <= 1'b0;
      cnt_r     <= '0;
      insn_r    <= 32'h0000_0000;
      rs1_r     <= 32'h0000_0000;
      rs2_r     <= 32'h0000_0000;
      rsp_wr_r  <= 1'b0;
      rsp_rd_r  <= 32'h0000_0000;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timeout_r <= timeout_s;
      if (accept_s) begin
        insn_r    <= pcpi_insn;
        rs1_r     <= pcpi_rs1;
        rs2_r     <= pcpi_rs2;
        sel_div_r <= pcpi_insn[14];
        cnt_r     <= '0;
      end else if (state_r == ST_ISSUE) begin
        cnt_r <= cnt_inc_s;
      end
      if ((state_r == ST_ISSUE) && unit_ready_s) begin
        rsp_wr_r <= unit_wr_s;
        rsp_rd_r <= unit_rd_s;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    mul_valid   = (state_r == ST_ISSUE) && !sel_div_r;
    div_valid   = (state_r == ST_ISSUE) && sel_div_r;
    pcpi_wait   = (state_r == ST_ISSUE);
    pcpi_ready  = (state_r == ST_RESP);
    pcpi_wr     = (state_r == ST_RESP) && rsp_wr_r;
    timeout_evt = timeout_r;
    if (state_r == ST_RESP) begin
      pcpi_rd = rsp_rd_r;
    end else begin
      pcpi_rd = 32'h0000_0000;
    end
    if (state_r != ST_IDLE) begin
      unit_insn = insn_r;
      unit_rs1  = rs1_r;
      unit_rs2  = rs2_r;
    end else begin
      unit_insn = 32'h0000_0000;
      unit_rs1  = 32'h0000_0000;
      unit_rs2  = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_picorv32_pcpi_mdu_ctrl.sv
// tb_picorv32_pcpi_mdu_ctrl
// Directed bench for the PCPI multiply/divide controller.
// The bench plays the role of both the core and the two arithmetic units.
// Instance "dut" uses the default timeout.
// Instance "dut_to" has TIMEOUT_CYCLES=8 and its units are stubbed so they never answer.
module tb_picorv32_pcpi_mdu_ctrl;

  localparam logic [31:0] I_MUL  = 32'h0220_81B3;
  localparam logic [31:0] I_DIV  = 32'h0220_C1B3;
  localparam logic [31:0] I_DIVU = 32'h0220_D1B3;
  localparam logic [31:0] I_REM  = 32'h0220_E1B3;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;

  logic clk = 1'b0;
  logic reset;
  logic pcpi_valid, t_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic pcpi_wr, pcpi_wait, pcpi_ready, mul_valid, div_valid, timeout_evt;
  logic [31:0] pcpi_rd, unit_insn, unit_rs1, unit_rs2;
  logic mul_wr, mul_wait, mul_ready, div_wr, div_wait, div_ready;
  logic [31:0] mul_rd, div_rd;
  logic t_wr, t_wait, t_ready, t_mul_valid, t_div_valid, t_timeout;
  logic [31:0] t_rd, t_unit_insn, t_unit_rs1, t_unit_rs2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  picorv32_pcpi_mdu_ctrl dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mul_valid(mul_valid), .div_valid(div_valid),
    .unit_insn(unit_insn), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
    .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
    .timeout_evt(timeout_evt)
  );

  picorv32_pcpi_mdu_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .reset(reset),
    .pcpi_valid(t_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(t_wr), .pcpi_rd(t_rd), .pcpi_wait(t_wait), .pcpi_ready(t_ready),
    .mul_valid(t_mul_valid), .div_valid(t_div_valid),
    .unit_insn(t_unit_insn), .unit_rs1(t_unit_rs1), .unit_rs2(t_unit_rs2),
    .mul_wr(1'b0), .mul_rd(32'h0000_0000), .mul_wait(1'b0), .mul_ready(1'b0),
    .div_wr(1'b0), .div_rd(32'h0000_0000), .div_wait(1'b0), .div_ready(1'b0),
    .timeout_evt(t_timeout)
  );

  // Advance one clock; outputs are sampled and inputs driven 2 ns after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every core-facing and unit-facing output of the main instance must be zero
  task automatic chk_quiet(input string tag);
    chk(tag, {26'd0, mul_valid, div_valid, pcpi_wait, pcpi_ready, pcpi_wr, timeout_evt}, 32'h0);
    chk(tag, pcpi_rd | unit_insn | unit_rs1 | unit_rs2, 32'h0);
  endtask

  // One complete request: lat extra ISSUE cycles before the unit answers,
  // hold cycles of pcpi_valid kept high after the response
  task automatic do_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic is_div, input logic [31:0] rdv,
                       input int lat, input int hold);
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
    tick();
    chk({tag, "_wait"}, {31'd0, pcpi_wait}, 32'd1);
    chk({tag, "_mulv"}, {31'd0, mul_valid}, {31'd0, !is_div});
    chk({tag, "_divv"}, {31'd0, div_valid}, {31'd0, is_div});
    chk({tag, "_uinsn"}, unit_insn, insn);
    chk({tag, "_urs1"}, unit_rs1, a);
    chk({tag, "_urs2"}, unit_rs2, b);
    for (int i = 0; i < lat; i++) begin
      // The non-selected unit answers once with junk; it must be ignored
      if (i == 0) begin
        if (is_div) begin mul_ready = 1'b1; mul_rd = 32'hDEAD_BEEF; mul_wr = 1'b1; end
        else begin div_ready = 1'b1; div_rd = 32'hDEAD_BEEF; div_wr = 1'b1; end
      end
      tick();
      mul_ready = 1'b0; div_ready = 1'b0;
      chk({tag, "_busy_wait"}, {30'd0, pcpi_wait, pcpi_ready}, 32'd2);
      chk({tag, "_busy_valid"}, {30'd0, mul_valid, div_valid}, {30'd0, !is_div, is_div});
    end
    if (is_div) begin div_ready = 1'b1; div_rd = rdv; div_wr = 1'b1; end
    else begin mul_ready = 1'b1; mul_rd = rdv; mul_wr = 1'b1; end
    tick();
    mul_ready = 1'b0; div_ready = 1'b0; mul_wr = 1'b0; div_wr = 1'b0;
    mul_rd = 32'h0; div_rd = 32'h0;
    chk({tag, "_ready"}, {31'd0, pcpi_ready}, 32'd1);
    chk({tag, "_wr"}, {31'd0, pcpi_wr}, 32'd1);
    chk({tag, "_rd"}, pcpi_rd, rdv);
    chk({tag, "_resp_ctl"}, {29'd0, mul_valid, div_valid, pcpi_wait}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold"}, {28'd0, mul_valid, div_valid, pcpi_wait, pcpi_ready}, 32'd0);
    end
    pcpi_valid = 1'b0;
    tick();
    chk({tag, "_drain_ready"}, {31'd0, pcpi_ready}, 32'd0);
    chk({tag, "_drain_rd"}, pcpi_rd, 32'd0);
    tick();
  endtask

  int n_wait, n_to, n_rdy, to_at;

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0; t_valid = 1'b0;
    pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
    mul_wr = 1'b0; mul_rd = 32'h0; mul_wait = 1'b0; mul_ready = 1'b0;
    div_wr = 1'b0; div_rd = 32'h0; div_wait = 1'b0; div_ready = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    reset = 1'b0;
    tick();
    chk_quiet("idle");

    // MUL 7*6, unit answers in the first ISSUE cycle (minimum latency)
    do_op("mul", I_MUL, 32'd7, 32'd6, 1'b0, 32'd42, 0, 0);
    // DIV -20/3 = -6, REM -20/3 = -2, DIVU x/0 = all ones
    do_op("div", I_DIV, 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFA, 3, 0);
    do_op("rem", I_REM, 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFE, 2, 0);
    do_op("divu0", I_DIVU, 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 1, 0);

    // Non-M instruction held for 50 cycles is ignored
    pcpi_valid = 1'b1; pcpi_insn = I_ADD; pcpi_rs1 = 32'd5; pcpi_rs2 = 32'd9;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_quiet("add_ignored");
    end
    pcpi_valid = 1'b0;
    tick();

    // Core holds valid 3 cycles past ready; then the next request is accepted
    do_op("hold", I_MUL, 32'd3, 32'd4, 1'b0, 32'd12, 1, 3);
    do_op("after_hold", I_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 0, 0);

    // Timeout: stubbed units never answer, limit 8
    t_valid = 1'b1; pcpi_insn = I_MUL; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2;
    n_wait = 0; n_to = 0; n_rdy = 0; to_at = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (t_wait) n_wait++;
      if (t_timeout) begin n_to++; to_at = i; end
      if (t_ready || t_wr || (t_rd != 32'h0) || t_div_valid) n_rdy++;
      if (i == 0) chk("to_unit_insn", t_unit_insn, I_MUL);
      if (i == 0) chk("to_mul_valid", {31'd0, t_mul_valid}, 32'd1);
    end
    chk("to_wait_cycles", n_wait, 32'd8);
    chk("to_pulses", n_to, 32'd1);
    chk("to_pulse_at", to_at, 32'd8);
    chk("to_no_ready", n_rdy, 32'd0);
    t_valid = 1'b0;
    tick();
    chk("to_idle_unit", t_unit_rs1 | t_unit_rs2, 32'd0);

    // Reset 10 cycles into a DIV, late div_ready 5 cycles after reset
    pcpi_valid = 1'b1; pcpi_insn = I_DIV; pcpi_rs1 = 32'd50; pcpi_rs2 = 32'd5;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("rst_div_valid", {30'd0, mul_valid, div_valid}, 32'd1);
      tick();
    end
    reset = 1'b1; pcpi_valid = 1'b0;
    tick();
    chk_quiet("rst_mid_issue");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("rst_after");
    end
    div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd10;
    tick();
    div_ready = 1'b0; div_wr = 1'b0; div_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("rst_late_ready");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
